int_pending_arb: RTL

- Interrupt request front end; sits directly upstream of the interrupt/eret controller.
- Edge-detects three external interrupt sources and holds them pending.
- Arbitrates the pending sources by fixed priority against the current in-service level, then issues the break pulse and 2-bit code to the controller.
- Keeps a nested EPC stack: pushed on each break, supplies the eret return address, popped on the controller's IG completion one-hot.

---
 rtl/int_pending_arb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/int_pending_arb.sv
// rtl/int_pending_arb.sv - interrupt edge detect, pending hold, priority take and nested EPC stack
// Optional INT_ERR_EN adds a sticky out_err flag for malformed completions and depth-blocked takes.
module int_pending_arb #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 3
) (
    input  logic            in_CLK,
    input  logic            in_RST,
    input  logic [2:0]      in_req,
    input  logic [2:0]      in_mask,
    input  logic            in_NIE,
    input  logic            in_stall,
    input  logic            in_eret,
    input  logic [3:0]      in_IG,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_BK,
    output logic [1:0]      out_code,
    output logic [PC_W-1:0] out_EPC,
    output logic [2:0]      out_pending,
    output logic [1:0]      out_level
`ifdef INT_ERR_EN
    ,
    output logic            out_err
`endif
);

    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    logic [2:0]      req_q;
    logic [2:0]      pending_q;
    logic            bk_q;
    logic [1:0]      code_q;
    logic [1:0]      level_q;
    logic [1:0]      stk_code [DEPTH];
    logic [PC_W-1:0] stk_pc   [DEPTH];

    logic [2:0]      rise;
    logic [2:0]      avail;
    logic [1:0]      cand;
    logic [2:0]      cand_oh;
    logic [1:0]      top_code;
    logic [PC_W-1:0] top_pc;
    logic            gate_ok;
    logic            take;
    logic            pop;

    assign rise  = in_req & ~req_q;
    assign avail = pending_q & ~in_mask;

    always_comb begin
        cand    = 2'd0;
        cand_oh = 3'b000;
        if (avail[2]) begin
            cand    = 2'd3;
            cand_oh = 3'b100;
        end else if (avail[1]) begin
            cand    = 2'd2;
            cand_oh = 3'b010;
        end else if (avail[0]) begin
            cand    = 2'd1;
            cand_oh = 3'b001;
        end
    end

    // Stack is indexed by level-1; an empty stack reads as code 0 / PC 0.
    always_comb begin
        top_code = 2'd0;
        top_pc   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == 2'(i + 1)) begin
                top_code = stk_code[i];
                top_pc   = stk_pc[i];
            end
        end
    end

    // Everything except the level limit; shared with the depth-blocked error check.
    assign gate_ok = (cand != 2'd0) && (cand > top_code) && in_NIE && !in_stall
                     && !in_eret && (in_IG == 4'b0000) && !bk_q;
    assign take    = gate_ok && (level_q < DEPTH_L);
    assign pop     = (in_IG != 4'b0000) && (level_q != 2'd0);

    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            req_q     <= 3'b000;
            pending_q <= 3'b000;
            bk_q      <= 1'b0;
            code_q    <= 2'd0;
            level_q   <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_code[i] <= 2'd0;
                stk_pc[i]   <= '0;
            end
        end else begin
            req_q <= in_req;
            // A fresh edge on the source being taken re-arms it.
            pending_q <= (pending_q & ~(take ? cand_oh : 3'b000)) | rise;
            bk_q      <= take;
            if (take) begin
                code_q  <= cand;
                level_q <= level_q + 2'd1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (level_q == 2'(i)) begin
                        stk_code[i] <= cand;
                        stk_pc[i]   <= in_pc;
                    end
                end
            end else if (pop) begin
                level_q <= level_q - 2'd1;
            end
        end
    end

`ifdef INT_ERR_EN
    logic [3:0] exp_ig;
    logic       err_q;

    always_comb begin
        exp_ig = 4'b0000;
        case (top_code)
            2'd1:    exp_ig = 4'b0001;
            2'd2:    exp_ig = 4'b0010;
            2'd3:    exp_ig = 4'b0100;
            default: exp_ig = 4'b0000;
        endcase
    end

    // exp_ig is zero on an empty stack, so this also catches a pop at level 0.
    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            err_q <= 1'b0;
        end else if (((in_IG != 4'b0000) && (in_IG != exp_ig))
                     || (gate_ok && (level_q == DEPTH_L))) begin
            err_q <= 1'b1;
        end
    end

    assign out_err = err_q;
`endif

    assign out_BK      = bk_q;
    assign out_code    = code_q;
    assign out_EPC     = top_pc;
    assign out_pending = pending_q;
    assign out_level   = level_q;

endmodule
